fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the 5-stage pipeline: owns the PC, drives imem, buffers returned

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_queue.sv | 81 ++++++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared defaults and helpers for the fetch front end (fetch_unit, fetch_queue).
// Queue entries are packed as {pc, insn}, with the instruction in the low bits.
package fetch_unit_pkg;

    localparam int          ADDR_W_DEFAULT   = 32;
    localparam int          INSN_W_DEFAULT   = 32;
    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;
    localparam int          INSN_LSB         = 0;
    localparam logic [31:0] PERF_MAX         = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != PERF_MAX)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetched {pc, insn} entries with flush, push and pop.
// Flush has priority over push/pop; a push while full is legal only together with a pop.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    pop_not_empty: assert property (@(posedge clock) disable iff (reset) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads, queues responses and hands them to decode.
// Define FETCH_PERF_EN to add saturating stall/flush performance counter ports.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                INSN_W   = INSN_W_DEFAULT,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(NOP_INSN_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_imem,
    input  logic [INSN_W-1:0] q_imem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fd_valid,
    input  logic              fd_ready,
    output logic [INSN_W-1:0] fd_insn,
    output logic [ADDR_W-1:0] fd_pc,
    output logic [ADDR_W-1:0] fd_pc_plus1
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PC_LSB  = INSN_LSB + INSN_W;
    localparam int ENTRY_W = ADDR_W + INSN_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     occupancy;
    logic               q_full, q_empty;
    logic               transfer, issue, resp_push;

    // Occupancy counts the response still in flight so an issue never overruns the queue.
    always_comb begin
        fd_valid    = ~q_empty & ~redirect_valid;
        transfer    = fd_valid & fd_ready;
        occupancy   = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(transfer);
        issue       = ~redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));
        resp_push   = inflight_q & ~redirect_valid;
        inflight_d  = issue;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d     = pc_q + ADDR_W'(1);
            req_pc_d = pc_q;
        end
        fd_insn     = fd_valid ? head[INSN_LSB +: INSN_W] : NOP_INSN;
        fd_pc       = fd_valid ? head[PC_LSB +: ADDR_W] : '0;
        fd_pc_plus1 = fd_valid ? head[PC_LSB +: ADDR_W] + ADDR_W'(1) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign address_imem = pc_q;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_queue (
        .clock   (clock),
        .reset   (reset),
        .flush   (redirect_valid),
        .push    (resp_push),
        .pop     (transfer),
        .wr_data ({req_pc_q, q_imem}),
        .rd_data (head),
        .count   (count),
        .full    (q_full),
        .empty   (q_empty)
    );

    no_overflow: assert property (@(posedge clock) disable iff (reset) !(resp_push && q_full && !transfer));

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, fd_valid & ~fd_ready);
        flush_cnt_d = sat_inc(flush_cnt_q, redirect_valid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (8-bit PC build, DEPTH=2); imem word at address a is 0x100+a.
module tb_fetch_unit;

    localparam int          ADDR_W = 8;
    localparam int          INSN_W = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address_imem;
    logic [INSN_W-1:0] q_imem = '0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              fd_valid;
    logic              fd_ready = 1'b1;
    logic [INSN_W-1:0] fd_insn;
    logic [ADDR_W-1:0] fd_pc;
    logic [ADDR_W-1:0] fd_pc_plus1;
    int                checkCount = 0;
    int                passCount = 0;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;
`endif

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSN_W   (INSN_W),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00),
        .NOP_INSN (NOP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .address_imem   (address_imem),
        .q_imem         (q_imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_insn        (fd_insn),
        .fd_pc          (fd_pc),
        .fd_pc_plus1    (fd_pc_plus1)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] imemWord(input logic [7:0] addr);
        return 32'h0000_0100 + {24'h0, addr};
    endfunction

    // Synchronous imem: data for the presented address appears one cycle later.
    always @(posedge clock) begin
        q_imem <= imemWord(address_imem);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [7:0] target);
        @(posedge clock);
        #1;
        fd_ready       = ready;
        redirect_valid = redir;
        redirect_pc    = target;
        #1;
    endtask

    task automatic checkFetch(input string tag, input logic valid, input logic [7:0] pc);
        checkOutput({tag, ".valid"}, 32'(fd_valid), 32'(valid));
        if (valid) begin
            checkOutput({tag, ".pc"}, 32'(fd_pc), 32'(pc));
            checkOutput({tag, ".insn"}, fd_insn, imemWord(pc));
            checkOutput({tag, ".pc_plus1"}, 32'(fd_pc_plus1), 32'(8'(pc + 8'd1)));
        end else begin
            checkOutput({tag, ".insn"}, fd_insn, NOP);
            checkOutput({tag, ".pc"}, 32'(fd_pc), 32'h0);
        end
    endtask

    task automatic checkAddr(input string tag, input logic [7:0] addr);
        checkOutput(tag, 32'(address_imem), 32'(addr));
    endtask

    initial begin
        // Reset state, then release and stream with decode always ready
        repeat (2) @(posedge clock);
        #1;
        checkFetch("reset", 1'b0, 8'h00);
        checkAddr("reset.addr", 8'h00);
        reset = 1'b0;
        #1;
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t1.c1", 1'b0, 8'h00);
        checkAddr("t1.c1.addr", 8'h01);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkFetch("t1.stream", 1'b1, 8'(k - 2));
        end

        // Five stall cycles with fd_pc=4; issue stops at PC 4+DEPTH
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkFetch("t2.stall", 1'b1, 8'h04);
            checkAddr("t2.stall.addr", 8'h06);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkFetch("t2.release", 1'b1, 8'(4 + k));
        end

        // Fill the queue, then redirect to 0x40
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkFetch("t3.fill", 1'b1, 8'h07);
        applyStimulus(1'b1, 1'b1, 8'h40);
        checkFetch("t3.redir", 1'b0, 8'h00);
        checkAddr("t3.redir.addr", 8'h09);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t3.r1", 1'b0, 8'h00);
        checkAddr("t3.r1.addr", 8'h40);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t3.r2", 1'b0, 8'h00);
        checkAddr("t3.r2.addr", 8'h41);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t3.r3", 1'b1, 8'h40);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t3.r4", 1'b1, 8'h41);

        // Back-to-back redirects (last wins) into the PC wrap boundary
        applyStimulus(1'b1, 1'b1, 8'h10);
        checkFetch("t4.redirA", 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hFE);
        checkFetch("t4.redirB", 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t4.w1", 1'b0, 8'h00);
        checkAddr("t4.w1.addr", 8'hFE);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t4.w2", 1'b0, 8'h00);
        checkAddr("t4.w2.addr", 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t4.w3", 1'b1, 8'hFE);
        checkAddr("t4.w3.addr", 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t4.w4", 1'b1, 8'hFF);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t4.w5", 1'b1, 8'h00);

        // Stall until two entries are queued, then reset mid-stall
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkFetch("t5.stall1", 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkFetch("t5.stall2", 1'b1, 8'h01);
`ifdef FETCH_PERF_EN
        checkOutput("t6.stall_cnt", perf_stall_cnt, 32'd7);
        checkOutput("t6.flush_cnt", perf_flush_cnt, 32'd3);
`endif
        reset = 1'b1;
        #1;
        checkFetch("t5.reset", 1'b0, 8'h00);
        checkAddr("t5.reset.addr", 8'h00);
`ifdef FETCH_PERF_EN
        checkOutput("t6.stall_cnt.reset", perf_stall_cnt, 32'd0);
        checkOutput("t6.flush_cnt.reset", perf_flush_cnt, 32'd0);
`endif
        @(posedge clock);
        #1;
        reset    = 1'b0;
        fd_ready = 1'b1;
        #1;
        checkAddr("t5.resume.addr", 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t5.c1", 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t5.c2", 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkFetch("t5.c3", 1'b1, 8'h01);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
